// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: controller states, S-array depth and default key length.
package rc4_pkg;

  localparam int SBOX_DEPTH    = 256;
  localparam int KEY_BYTES_DEF = 16;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    KSA_RD,
    KSA_SWAP,
    PRGA_RDI,
    PRGA_RDJ,
    PRGA_SWAP,
    PRGA_RDT,
    PRGA_OUT
  } state_t;

  function automatic logic is_prga(input state_t s);
    return (s inside {PRGA_RDI, PRGA_RDJ, PRGA_SWAP, PRGA_RDT, PRGA_OUT});
  endfunction

endpackage

// File: rtl/rc4_core.sv
// RC4 keystream engine: controller plus its private S-array.
module rc4_core
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  output logic [7:0]             ks_o,
  output logic                   ks_valid_o,
  input  logic                   ks_ready_i,
  output logic                   busy_o
);

  logic [7:0] w_waddr, w_wdata, w_raddr, w_rdata;
  logic       w_wenable, w_renable, w_swap;

  rc4_ctrl #(.KEY_BYTES(KEY_BYTES)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .key_i      (key_i),
    .ks_o       (ks_o),
    .ks_valid_o (ks_valid_o),
    .ks_ready_i (ks_ready_i),
    .busy_o     (busy_o),
    .waddr_o    (w_waddr),
    .wdata_o    (w_wdata),
    .raddr_o    (w_raddr),
    .wenable_o  (w_wenable),
    .renable_o  (w_renable),
    .swap_o     (w_swap),
    .rdata_i    (w_rdata)
  );

  sarr u_sarr (
    .clk       (clk),
    .waddr_i   (w_waddr),
    .wdata_i   (w_wdata),
    .raddr_i   (w_raddr),
    .wenable_i (w_wenable),
    .renable_i (w_renable),
    .swap_i    (w_swap),
    .rdata_o   (w_rdata)
  );

endmodule

// File: rtl/sarr.sv
// 256x8 RC4 state array: one-cycle registered read, single write, or in-place swap
// of S[raddr_i] and S[waddr_i] at one clock edge.
module sarr
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  input  logic       wenable_i,
  input  logic       renable_i,
  input  logic       swap_i,
  output logic [7:0] rdata_o
);

  logic [7:0] r_mem [SBOX_DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (renable_i) r_rdata <= r_mem[raddr_i];
    if (wenable_i) begin
      r_mem[waddr_i] <= wdata_i;
    end else if (swap_i) begin
      r_mem[waddr_i] <= r_mem[raddr_i];
      r_mem[raddr_i] <= r_mem[waddr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/rc4_ctrl.sv
// RC4 controller: initialises and key-schedules an external S-array, then produces
// one keystream byte per five cycles with a valid/ready handshake.
module rc4_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  output logic [7:0]             ks_o,
  output logic                   ks_valid_o,
  input  logic                   ks_ready_i,
  output logic                   busy_o,
  output logic [7:0]             waddr_o,
  output logic [7:0]             wdata_o,
  output logic [7:0]             raddr_o,
  output logic                   wenable_o,
  output logic                   renable_o,
  output logic                   swap_o,
  input  logic [7:0]             rdata_i
);

  localparam int KW = 8 * KEY_BYTES;

  state_t        r_state, w_state_next;
  logic [7:0]    r_i, r_j, r_si, r_t, r_ks;
  logic [7:0]    w_i_next, w_j_next, w_si_next, w_t_next;
  logic [7:0]    w_i_inc, w_j_ksa, w_j_prga, w_ks;
  logic          r_fresh;
  logic [KW-1:0] r_key, w_key_next, w_key_rot;

  assign w_i_inc  = r_i + 8'd1;
  assign w_j_ksa  = r_j + rdata_i + r_key[KW-1 -: 8];
  assign w_j_prga = r_j + rdata_i;

  // The key is rotated one byte per KSA step so the MSB byte is always K[i mod KEY_BYTES].
  generate
    if (KEY_BYTES == 1) begin : g_key_one
      assign w_key_rot = r_key;
    end else begin : g_key_many
      assign w_key_rot = {r_key[KW-9:0], r_key[KW-1 -: 8]};
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_i_next     = r_i;
    w_j_next     = r_j;
    w_si_next    = r_si;
    w_t_next     = r_t;
    w_key_next   = r_key;
    waddr_o      = 8'd0;
    wdata_o      = 8'd0;
    raddr_o      = 8'd0;
    wenable_o    = 1'b0;
    renable_o    = 1'b0;
    swap_o       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next = INIT;
          w_key_next   = key_i;
          w_i_next     = 8'd0;
          w_j_next     = 8'd0;
        end
      end
      INIT: begin
        wenable_o = 1'b1;
        waddr_o   = r_i;
        wdata_o   = r_i;
        w_i_next  = w_i_inc;
        if (r_i == 8'hFF) w_state_next = KSA_RD;
      end
      KSA_RD: begin
        renable_o    = 1'b1;
        raddr_o      = r_i;
        w_state_next = KSA_SWAP;
      end
      KSA_SWAP: begin
        swap_o     = 1'b1;
        raddr_o    = r_i;
        waddr_o    = w_j_ksa;
        w_j_next   = w_j_ksa;
        w_i_next   = w_i_inc;
        w_key_next = w_key_rot;
        if (r_i == 8'hFF) begin
          w_j_next     = 8'd0;
          w_state_next = PRGA_RDI;
        end else begin
          w_state_next = KSA_RD;
        end
      end
      PRGA_RDI: begin
        renable_o    = 1'b1;
        raddr_o      = w_i_inc;
        w_i_next     = w_i_inc;
        w_state_next = PRGA_RDJ;
      end
      PRGA_RDJ: begin
        renable_o    = 1'b1;
        raddr_o      = w_j_prga;
        w_si_next    = rdata_i;
        w_j_next     = w_j_prga;
        w_state_next = PRGA_SWAP;
      end
      PRGA_SWAP: begin
        swap_o       = 1'b1;
        raddr_o      = r_i;
        waddr_o      = r_j;
        w_t_next     = r_si + rdata_i;
        w_state_next = PRGA_RDT;
      end
      PRGA_RDT: begin
        renable_o    = 1'b1;
        raddr_o      = r_t;
        w_state_next = PRGA_OUT;
      end
      PRGA_OUT: begin
        if (ks_ready_i) w_state_next = PRGA_RDI;
      end
      default: w_state_next = IDLE;
    endcase
    if (stop_i && is_prga(r_state)) w_state_next = IDLE;
  end

  // S[t] lands on rdata_i during the first PRGA_OUT cycle; it is captured there and
  // held, so ks_o stays stable however long the consumer stalls.
  assign w_ks = r_fresh ? rdata_i : r_ks;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_si    <= 8'd0;
      r_t     <= 8'd0;
      r_ks    <= 8'd0;
      r_fresh <= 1'b0;
      r_key   <= '0;
    end else begin
      r_state <= w_state_next;
      r_i     <= w_i_next;
      r_j     <= w_j_next;
      r_si    <= w_si_next;
      r_t     <= w_t_next;
      r_key   <= w_key_next;
      r_fresh <= (w_state_next == PRGA_OUT) && (r_state != PRGA_OUT);
      if (r_state == PRGA_OUT) r_ks <= w_ks;
    end
  end

  assign ks_o       = w_ks;
  assign ks_valid_o = (r_state == PRGA_OUT);
  assign busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_rc4_ctrl.sv
// Directed bench for rc4_ctrl with its S-array, plus an rc4_core run in lockstep;
// expected bytes come from published vectors and a software RC4 model.
module tb_rc4_ctrl;

  localparam logic [127:0] K1 = 128'h0102030405060708090a0b0c0d0e0f10;
  localparam logic [127:0] K2 = 128'h3c5a96e1_0f1e2d4b_a5c3b279_11223344;
  localparam logic [127:0] K3 = 128'hfedcba98_76543210_0badf00d_c0ffee01;

  logic         clk = 1'b0;
  logic         reset, start_i, stop_i, ks_ready_i;
  logic [127:0] key_i;
  logic [7:0]   ks_o, waddr_o, wdata_o, raddr_o, rdata_i, core_ks;
  logic         ks_valid_o, busy_o, wenable_o, renable_o, swap_o;
  logic         core_valid, core_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int ctl_viol = 0;
  int last_wait = 0;
  int lat = 0;
  logic mon_en = 1'b0;
  logic [7:0] exp_ks [300];
  logic [7:0] k1_exp [8] = '{8'h9a, 8'hc7, 8'hcc, 8'h9a, 8'h60, 8'h9d, 8'h1e, 8'hf7};

  always #5 clk = ~clk;

  rc4_ctrl #(.KEY_BYTES(16)) u_dut (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i), .key_i(key_i),
    .ks_o(ks_o), .ks_valid_o(ks_valid_o), .ks_ready_i(ks_ready_i), .busy_o(busy_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .raddr_o(raddr_o), .wenable_o(wenable_o),
    .renable_o(renable_o), .swap_o(swap_o), .rdata_i(rdata_i)
  );

  sarr u_sarr (
    .clk(clk), .waddr_i(waddr_o), .wdata_i(wdata_o), .raddr_i(raddr_o),
    .wenable_i(wenable_o), .renable_i(renable_o), .swap_i(swap_o), .rdata_o(rdata_i)
  );

  rc4_core #(.KEY_BYTES(16)) u_core (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i), .key_i(key_i),
    .ks_o(core_ks), .ks_valid_o(core_valid), .ks_ready_i(ks_ready_i), .busy_o(core_busy)
  );

  // S-array controls must be mutually exclusive and silent in IDLE and while a byte is offered.
  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(wenable_o) + int'(renable_o) + int'(swap_o) > 1) ctl_viol++;
      if ((!busy_o || ks_valid_o) && (wenable_o || renable_o || swap_o)) ctl_viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_rc4(input logic [127:0] key, input int n);
    logic [7:0] s [256];
    logic [7:0] tmp;
    int i, j;
    for (int k = 0; k < 256; k++) s[k] = k[7:0];
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + int'(s[k]) + int'(key[127-8*(k%16) -: 8])) % 256;
      tmp = s[k]; s[k] = s[j]; s[j] = tmp;
    end
    i = 0;
    j = 0;
    for (int k = 0; k < n; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      exp_ks[k] = s[(int'(s[i]) + int'(s[j])) % 256];
    end
  endtask

  // Pulse start with key; optional stop/start pulses at given cycle offsets; check latency.
  task automatic run_start(input string tag, input logic [127:0] key, input int stop_at,
                           input int start_at);
    key_i   = key;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    key_i   = ~key;
    lat     = 0;
    while (!ks_valid_o && lat < 2000) begin
      stop_i  = (lat == stop_at);
      start_i = (lat == start_at);
      tick();
      lat++;
    end
    stop_i  = 1'b0;
    start_i = 1'b0;
    check({tag, "_latency"}, lat, 772);
  endtask

  task automatic get_byte(input string tag, input logic [7:0] exp);
    int w = 0;
    while (!ks_valid_o && w < 50) begin
      tick();
      w++;
    end
    last_wait = w;
    check(tag, {23'd0, ks_valid_o, ks_o}, {23'd0, 1'b1, exp});
    check({tag, "_core"}, {23'd0, core_valid, core_ks}, {23'd0, 1'b1, exp});
    if (ks_ready_i) tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_valid"}, ks_valid_o, 0);
    check({tag, "_ctl"}, {wenable_o, renable_o, swap_o}, 0);
    check({tag, "_core_busy"}, core_busy, 0);
  endtask

  initial begin
    int held_bad;
    int w;
    reset = 1'b1; start_i = 1'b0; stop_i = 1'b0; ks_ready_i = 1'b1; key_i = '0;
    repeat (3) tick();
    check_idle("rst");
    check("rst_ks", ks_o, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // A: published vector, back-to-back consumption, 5-cycle byte spacing
    run_start("A", K1, -1, -1);
    for (int b = 0; b < 8; b++) begin
      get_byte($sformatf("A_byte%0d", b), k1_exp[b]);
      if (b == 1) check("A_spacing", last_wait, 4);
    end
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    check_idle("A_stop");

    // B: stall on byte 1, start pulses in KSA and PRGA, stop with a byte pending
    run_start("B", K1, -1, 400);
    get_byte("B_byte0", k1_exp[0]);
    ks_ready_i = 1'b0;
    w = 0;
    while (!ks_valid_o && w < 50) begin tick(); w++; end
    held_bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (ks_o !== 8'hc7 || ks_valid_o !== 1'b1) held_bad++;
      tick();
    end
    check("B_stall_hold", held_bad, 0);
    check("B_byte1", {23'd0, ks_valid_o, ks_o}, {23'd0, 1'b1, k1_exp[1]});
    ks_ready_i = 1'b1;
    tick();
    get_byte("B_byte2", k1_exp[2]);
    get_byte("B_byte3", k1_exp[3]);
    start_i = 1'b1; key_i = '0; tick(); start_i = 1'b0;
    for (int b = 4; b < 7; b++) get_byte($sformatf("B_byte%0d", b), k1_exp[b]);
    ks_ready_i = 1'b0;
    get_byte("B_byte7", k1_exp[7]);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    ks_ready_i = 1'b1;
    check_idle("B_stop");

    // C: all-zero key across the i 255->0 wrap
    model_rc4('0, 300);
    run_start("C", '0, -1, -1);
    for (int b = 0; b < 300; b++) get_byte($sformatf("C_byte%0d", b), exp_ks[b]);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    check_idle("C_stop");

    // D: stop pulses in INIT/KSA ignored; stop after byte 3 then restart with a new key
    model_rc4(K2, 4);
    run_start("D1", K2, 50, -1);
    for (int b = 0; b < 4; b++) get_byte($sformatf("D1_byte%0d", b), exp_ks[b]);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    check_idle("D1_stop");
    model_rc4(K3, 8);
    run_start("D2", K3, 500, -1);
    for (int b = 0; b < 8; b++) get_byte($sformatf("D2_byte%0d", b), exp_ks[b]);
    stop_i = 1'b1; tick(); stop_i = 1'b0;

    // E: reset mid-INIT and mid-KSA, reset beating start, then a clean restart
    key_i = K1; start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (100) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_idle("E_init_rst");
    check("E_init_rst_ks", ks_o, 0);
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (300) tick();
    reset = 1'b1; tick();
    check_idle("E_ksa_rst");
    check("E_ksa_rst_ks", ks_o, 0);
    start_i = 1'b1; tick();
    check_idle("E_rst_prio");
    reset = 1'b0; start_i = 1'b0;
    tick();
    run_start("E", K1, -1, -1);
    for (int b = 0; b < 4; b++) get_byte($sformatf("E_byte%0d", b), k1_exp[b]);

    check("ctl_exclusive_quiet", ctl_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rc4_ctrl.md
RC4_CTRL -- requirements
Module: rc4_ctrl

Interface
REQ-001 SHALL have parameter KEY_BYTES, default 16, key length in bytes.
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start_i, input, 1, one-cycle pulse; begins key schedule.
REQ-005 SHALL have port stop_i, input, 1, aborts keystream generation.
REQ-006 SHALL have port key_i, input, 8*KEY_BYTES, key; K[0] = key_i[MSB -: 8].
REQ-007 SHALL have port ks_o, output, 8, keystream byte.
REQ-008 SHALL have port ks_valid_o, output, 1, ks_o valid.
REQ-009 SHALL have port ks_ready_i, input, 1, consumer accepts ks_o.
REQ-010 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-011 SHALL have ports waddr_o, wdata_o, raddr_o (8 each), and wenable_o, renable_o, swap_o (1 each), output, S-array write, read and swap controls.
REQ-012 SHALL have port rdata_i, input, 8, S-array read data, valid one cycle after renable_o.

Function
REQ-013 SHALL treat the S-array as 256x8, with 1-cycle registered read; swap_o exchanges S[raddr_o] and S[waddr_o] at the clock edge.
REQ-014 SHALL implement states IDLE, INIT, KSA_RD, KSA_SWAP, PRGA_RDI, PRGA_RDJ, PRGA_SWAP, PRGA_RDT, PRGA_OUT.
REQ-015 IDLE: on start_i, SHALL latch key_i, clear i and j, and go to INIT; other inputs SHALL be ignored.
REQ-016 INIT: SHALL write S[i]=i for i=0..255, one per cycle (exactly 256 cycles), then clear i and go to KSA_RD.
REQ-017 KSA_RD: SHALL read S[i].
REQ-018 KSA_SWAP: SHALL compute j' = j + rdata_i + K[i mod KEY_BYTES] (mod 256), swap S[i] and S[j'], register j', and increment i.
REQ-019 KSA_SWAP: when i wraps 255->0, SHALL clear i and j and go to PRGA_RDI; otherwise go to KSA_RD (512 KSA cycles total).
REQ-020 PRGA_RDI: SHALL compute i+1 (mod 256) and read S[i+1].
REQ-021 PRGA_RDJ: SHALL register si=rdata_i, compute j = j + si, and read S[j].
REQ-022 PRGA_SWAP: SHALL swap S[i] and S[j] and register t = si + rdata_i (mod 256).
REQ-023 PRGA_RDT: SHALL read S[t].
REQ-024 PRGA_OUT: SHALL register ks_o = rdata_i on entry and hold ks_valid_o high with ks_o stable until ks_ready_i.
REQ-025 PRGA_OUT: on handshake (valid & ready), SHALL go to PRGA_RDI, so each byte takes 5 cycles minimum.
REQ-026 SHALL assert ks_valid_o exactly 772 cycles after the edge that samples start_i, given no stall.
REQ-027 SHALL allow i==j in any swap; a self-swap is a no-op and no special handling is needed.
REQ-028 SHALL wrap all index arithmetic mod 256.
REQ-029 SHALL return to IDLE next cycle on stop_i in any PRGA state, dropping ks_valid_o and discarding any unaccepted byte.
REQ-030 SHALL ignore stop_i in INIT and KSA.
REQ-031 SHALL ignore start_i while busy_o is high.
REQ-032 SHALL assert at most one of wenable_o, renable_o, swap_o per cycle.
REQ-033 SHALL drive S-array control outputs 0 in IDLE and PRGA_OUT.

Reset
REQ-034 On reset, SHALL go to IDLE, clear i, j, si, t and ks_o to 0, and drive ks_valid_o, busy_o, wenable_o, renable_o, swap_o to 0.
REQ-035 Reset mid-operation SHALL abandon the sequence without further S-array access; the next start_i SHALL fully re-initialise.
REQ-036 Reset SHALL take priority over start_i and stop_i.

Structure
REQ-037 Package rc4_pkg SHALL hold the state enum, SBOX_DEPTH=256 and the default KEY_BYTES.
REQ-038 Parent rc4_core SHALL instantiate rc4_ctrl and sarr; rc4_ctrl itself SHALL have no sub-module.

Verification
REQ-039 Key 0102...0f10, ks_ready_i=1 -> first 8 bytes 9a c7 cc 9a 60 9d 1e f7; first valid at cycle 772.
REQ-040 Same key, ks_ready_i low 10 cycles on byte 2 -> ks_o held at c7, no S-array access, stream otherwise identical.
REQ-041 Key all-zero, 300 bytes -> match software RC4 model across the i 255->0 wrap.
REQ-042 stop_i after byte 3, then start_i with new key -> IDLE in 1 cycle; new stream matches model from byte 0.
REQ-043 reset at INIT cycle 100 and at KSA cycle 300 -> all outputs 0 next cycle; restart produces correct stream.
REQ-044 start_i pulsed during KSA and PRGA -> ignored, stream unchanged.
